// File: rtl/cmd_pkg.sv
// cmd_pkg: opcodes, FSM state/phase enums and opcode legality shared by both ends of the command link
package cmd_pkg;
  localparam logic [7:0] ADD = 8'h0A;
  localparam logic [7:0] SUB = 8'h0B;
  localparam logic [7:0] AND = 8'h0C;
  localparam logic [7:0] OR  = 8'h0D;
  typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_A, SEND_B, WAIT_RES} state_t;
  typedef enum logic [1:0] {ISSUE, ACK, DRAIN} phase_t;
  function automatic logic legal_op(input logic [7:0] op);
    return op inside {ADD, SUB, AND, OR};
  endfunction
endpackage

// File: rtl/cmd_ref_alu.sv
// cmd_ref_alu: combinational 8-bit expected-result ALU (modulo 256)
module cmd_ref_alu
  import cmd_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  always_comb y = op == ADD ? a + b : op == SUB ? a - b : op == AND ? a & b : op == OR ? a | b : 8'h00;
endmodule

// File: rtl/cmd_issue.sv
// cmd_issue: serialises CMD/A/B to the UART TX, waits for one result byte with timeout
// Optional result checker enabled by defining CMD_CHECK_EN (adds check_fail port).
module cmd_issue
  import cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       req,
  input  logic [7:0] cmd_in,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err_cmd,
  output logic       err_timeout
`ifdef CMD_CHECK_EN
  ,
  output logic       check_fail
`endif
);
  state_t state, state_d;
  phase_t phase, phase_d;
  logic [15:0] cnt, cnt_d;
  logic [7:0] cmd_q, a_q, b_q, cmd_d, a_d, b_d, result_d;
  logic rv_d, ec_d, et_d;
  assign busy = state inside {SEND_CMD, SEND_A, SEND_B, WAIT_RES};
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    cnt_d    = cnt;
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result;
    rv_d     = 1'b0;
    ec_d     = 1'b0;
    et_d     = 1'b0;
    tx_en    = 1'b0;
    tx_data  = 8'h00;
    case (state)
      IDLE: if (req) begin
        if (legal_op(cmd_in)) begin
          cmd_d   = cmd_in;
          a_d     = a_in;
          b_d     = b_in;
          state_d = SEND_CMD;
          phase_d = ISSUE;
        end else ec_d = 1'b1;
      end
      SEND_CMD, SEND_A, SEND_B: begin
        tx_data = state == SEND_CMD ? cmd_q : state == SEND_A ? a_q : b_q;
        case (phase)
          ISSUE: if (!tx_busy) begin
            tx_en   = 1'b1;
            phase_d = ACK;
          end
          ACK: if (tx_busy) phase_d = DRAIN;
          DRAIN: if (!tx_busy) begin
            phase_d = ISSUE;
            cnt_d   = '0;
            state_d = state == SEND_CMD ? SEND_A : state == SEND_A ? SEND_B : WAIT_RES;
          end
          default: phase_d = ISSUE;
        endcase
      end
      WAIT_RES: begin
        // a reply arriving on the terminal-count cycle still counts as a reply
        if (rx_en) begin
          result_d = rx_data;
          rv_d     = 1'b1;
          state_d  = IDLE;
        end else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          et_d    = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt + 16'd1;
      end
      default: begin
        state_d = IDLE;
        phase_d = ISSUE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state        <= IDLE;
      phase        <= ISSUE;
      cnt          <= '0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err_cmd      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      phase        <= phase_d;
      cnt          <= cnt_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result       <= result_d;
      result_valid <= rv_d;
      err_cmd      <= ec_d;
      err_timeout  <= et_d;
    end
  end
`ifdef CMD_CHECK_EN
  logic [7:0] exp_res;
  cmd_ref_alu u_alu (.op(cmd_q), .a(a_q), .b(b_q), .y(exp_res));
  always_ff @(posedge clk or negedge res) begin
    if (!res) check_fail <= 1'b0;
    else check_fail <= state == WAIT_RES && rx_en && rx_data != exp_res;
  end
`endif
endmodule

// File: tb/tb_cmd_issue.sv
// tb_cmd_issue: scoreboard bench for cmd_issue with a simple UART TX busy model
module tb_cmd_issue;
  localparam int TO = 20;
  logic clk = 1'b0, res = 1'b0, req = 1'b0, tx_busy = 1'b0, rx_en = 1'b0;
  logic [7:0] cmd_in = '0, a_in = '0, b_in = '0, rx_data = '0;
  logic busy, tx_en, result_valid, err_cmd, err_timeout;
  logic [7:0] tx_data, result;
`ifdef CMD_CHECK_EN
  logic check_fail;
`endif
  int n_chk = 0, n_fail = 0, n_tx = 0, n_res = 0, n_ecmd = 0, n_eto = 0;
  int busy_len = 1, cyc = 0, last_tx_cyc = 0, eto_cyc = 0, tx0 = 0;
  logic [7:0] exp_tx[$];
  logic [8:0] exp_res[$];

  cmd_issue #(.TIMEOUT_CYCLES(16'(TO))) dut (
    .clk(clk), .res(res), .req(req), .cmd_in(cmd_in), .a_in(a_in), .b_in(b_in),
    .busy(busy), .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_en(rx_en), .result(result), .result_valid(result_valid),
    .err_cmd(err_cmd), .err_timeout(err_timeout)
`ifdef CMD_CHECK_EN
    , .check_fail(check_fail)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // transmitter model: busy for busy_len cycles after each strobe
  initial begin
    int seen = 0, left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (seen != n_tx) begin
        seen = n_tx;
        left = busy_len;
      end
      tx_busy = left > 0;
      if (left > 0) left--;
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx_en) begin
        n_tx++;
        last_tx_cyc = cyc;
        check("tx_en_while_busy", 32'(tx_busy), 0);
        if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
        else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
      if (result_valid) begin
        n_res++;
        check("busy_at_result", 32'(busy), 0);
        if (exp_res.size() == 0) check("result_unexpected", 1, 0);
        else begin
          e = exp_res.pop_front();
          check("result", 32'(result), 32'(e[7:0]));
`ifdef CMD_CHECK_EN
          check("check_fail", 32'(check_fail), 32'(e[8]));
`endif
        end
      end
      if (err_cmd) begin
        n_ecmd++;
        check("busy_at_err_cmd", 32'(busy), 0);
      end
      if (err_timeout) begin
        n_eto++;
        eto_cyc = cyc;
        check("busy_at_timeout", 32'(busy), 0);
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    req = 1'b1;
    cmd_in = c;
    a_in = a;
    b_in = b;
    if (c >= 8'h0A && c <= 8'h0D) begin
      exp_tx.push_back(c);
      exp_tx.push_back(a);
      exp_tx.push_back(b);
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    cmd_in = 8'($urandom);
    a_in = 8'($urandom);
    b_in = 8'($urandom);
  endtask

  task automatic wait_tx_done();
    int t = 0;
    while (exp_tx.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("tx_drain_timely", exp_tx.size(), 0);
    repeat (busy_len + 2) @(posedge clk);
  endtask

  task automatic reply(input logic [7:0] d, input logic [7:0] model);
    #1;
    rx_en = 1'b1;
    rx_data = d;
    exp_res.push_back({d != model, d});
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    rx_data = 8'($urandom);
    repeat (2) @(negedge clk);
  endtask

  task automatic stray(input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_en = 1'b1;
    rx_data = d;
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_result", 32'(result), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_err_cmd", 32'(err_cmd), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    res = 1'b1;
    stray(8'hAA);
    check("stray_idle_result", 32'(result), 0);
    send(8'h0A, 8'h30, 8'hD5);
    check("busy_after_req", 32'(busy), 1);
    wait_tx_done();
    reply(8'h05, 8'h05);
    check("add_busy_done", 32'(busy), 0);
    check("add_res_count", n_res, 1);
    send(8'h0B, 8'h10, 8'h20);
    wait_tx_done();
    reply(8'hF1, 8'hF0);
    check("sub_res_count", n_res, 2);
    tx0 = n_tx;
    send(8'h0E, 8'h01, 8'h02);
    repeat (4) @(negedge clk);
    check("illegal_err_cmd", n_ecmd, 1);
    check("illegal_no_tx", n_tx, tx0);
    check("illegal_busy", 32'(busy), 0);
    busy_len = 12;
    tx0 = n_tx;
    send(8'h0C, 8'hA5, 8'h3C);
    repeat (5) @(posedge clk);
    #1;
    req = 1'b1;
    cmd_in = 8'h0A;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_tx_done();
    check("bp_tx_count", n_tx - tx0, 3);
    reply(8'h24, 8'h24);
    check("bp_res_count", n_res, 3);
    busy_len = 1;
    send(8'h0D, 8'h01, 8'h02);
    wait_tx_done();
    t = 0;
    while (n_eto == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("timeout_count", n_eto, 1);
    check("timeout_latency", eto_cyc - last_tx_cyc, TO + 3);
    check("timeout_result_kept", 32'(result), 32'h24);
    stray(8'h77);
    check("stray_after_timeout", 32'(result), 32'h24);
    check("stray_no_valid", n_res, 3);
    tx0 = n_tx;
    send(8'h0A, 8'h11, 8'h22);
    t = 0;
    while (n_tx < tx0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_send_a", n_tx, tx0 + 2);
    #2;
    res = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_tx_en", 32'(tx_en), 0);
    check("arst_tx_data", 32'(tx_data), 0);
    check("arst_result", 32'(result), 0);
    check("arst_pulses", {29'b0, result_valid, err_cmd, err_timeout}, 0);
    exp_tx.delete();
    repeat (2) @(posedge clk);
    #3;
    res = 1'b1;
    repeat (4) @(posedge clk);
    check("no_resend", n_tx, tx0 + 2);
    send(8'h0D, 8'h0F, 8'hF0);
    wait_tx_done();
    reply(8'hFF, 8'hFF);
    check("post_rst_res_count", n_res, 4);
    check("post_rst_result", 32'(result), 32'hFF);
    check("total_err_cmd", n_ecmd, 1);
    check("total_timeout", n_eto, 1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
